// File: rtl/wb_stage_mc.sv
// Multi-cycle write-back stage: retires ALU results in one cycle, and holds loads
// in WAIT_MEM until the memory response arrives or the timeout expires.
module wb_stage_mc #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      MEM_R_EN,
   input  logic                      WB_EN,
   input  logic [REG_ADDR_WIDTH-1:0] Dest,
   input  logic [DATA_WIDTH-1:0]     ALU_res,
   input  logic [1:0]                ld_size,
   input  logic                      ld_signed,
   input  logic [1:0]                addr_lo,
   input  logic                      mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
   input  logic                      err_clr,
   output logic                      WB_EN_out,
   output logic [REG_ADDR_WIDTH-1:0] WB_Dest,
   output logic [DATA_WIDTH-1:0]     WB_Value,
   output logic                      busy,
   output logic [REG_ADDR_WIDTH-1:0] pending_dest,
   output logic                      err_timeout,
   output logic                      err_spurious
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [REG_ADDR_WIDTH-1:0] ld_dest_q, ld_dest_d;
   logic                      ld_wben_q, ld_wben_d;
   logic [1:0]                ld_size_q, ld_size_d;
   logic                      ld_signed_q, ld_signed_d;
   logic [1:0]                ld_addr_q, ld_addr_d;
   logic                      wb_en_q, wb_en_d;
   logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
   logic [DATA_WIDTH-1:0]     wb_value_q, wb_value_d;
   logic                      err_to_q, err_to_d;
   logic                      err_sp_q, err_sp_d;
   logic                      accept;

   // Sub-word lanes are always taken from the low 32 bits of the response.
   function automatic logic [DATA_WIDTH-1:0] extract_load(
      input logic [DATA_WIDTH-1:0] d,
      input logic [1:0]            sz,
      input logic                  sgn,
      input logic [1:0]            a
   );
      logic [15:0] h;
      logic [7:0]  b;
      h = a[1] ? d[31:16] : d[15:0];
      case (a)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      case (sz)
         2'b01:   extract_load = {{(DATA_WIDTH-16){sgn & h[15]}}, h};
         2'b10:   extract_load = {{(DATA_WIDTH-8){sgn & b[7]}}, b};
         default: extract_load = d;
      endcase
   endfunction

   assign in_ready = (state_q == S_IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_dest_d   = ld_dest_q;
      ld_wben_d   = ld_wben_q;
      ld_size_d   = ld_size_q;
      ld_signed_d = ld_signed_q;
      ld_addr_d   = ld_addr_q;
      wb_en_d     = 1'b0;
      wb_dest_d   = wb_dest_q;
      wb_value_d  = wb_value_q;
      err_to_d    = err_to_q & ~err_clr;
      err_sp_d    = err_sp_q & ~err_clr;

      case (state_q)
         S_IDLE: begin
            if (mem_rsp_valid) err_sp_d = 1'b1;
            if (accept) begin
               if (MEM_R_EN) begin
                  state_d     = S_WAIT_MEM;
                  cnt_d       = '0;
                  ld_dest_d   = Dest;
                  ld_wben_d   = WB_EN;
                  ld_size_d   = ld_size;
                  ld_signed_d = ld_signed;
                  ld_addr_d   = addr_lo;
               end else begin
                  wb_en_d    = WB_EN;
                  wb_dest_d  = Dest;
                  wb_value_d = ALU_res;
               end
            end
         end
         default: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_rsp_valid) begin
               state_d    = S_IDLE;
               wb_en_d    = ld_wben_q;
               wb_dest_d  = ld_dest_q;
               wb_value_d = extract_load(mem_rsp_data, ld_size_q, ld_signed_q, ld_addr_q);
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_IDLE;
               err_to_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ld_dest_q   <= '0;
         ld_wben_q   <= 1'b0;
         ld_size_q   <= 2'b00;
         ld_signed_q <= 1'b0;
         ld_addr_q   <= 2'b00;
         wb_en_q     <= 1'b0;
         wb_dest_q   <= '0;
         wb_value_q  <= '0;
         err_to_q    <= 1'b0;
         err_sp_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ld_dest_q   <= ld_dest_d;
         ld_wben_q   <= ld_wben_d;
         ld_size_q   <= ld_size_d;
         ld_signed_q <= ld_signed_d;
         ld_addr_q   <= ld_addr_d;
         wb_en_q     <= wb_en_d;
         wb_dest_q   <= wb_dest_d;
         wb_value_q  <= wb_value_d;
         err_to_q    <= err_to_d;
         err_sp_q    <= err_sp_d;
      end
   end

   assign WB_EN_out    = wb_en_q;
   assign WB_Dest      = wb_dest_q;
   assign WB_Value     = wb_value_q;
   assign busy         = (state_q == S_WAIT_MEM);
   assign pending_dest = busy ? ld_dest_q : '0;
   assign err_timeout  = err_to_q;
   assign err_spurious = err_sp_q;

endmodule
